breadboard_lut_sweep: RTL
=========================

Name: breadboard_lut_sweep

Overview:
- Parametrised, clocked successor of the fixed 4-input/10-output combinational breadboard.
- Holds one programmable truth table per output, loaded at run time.
- Direct mode: evaluates live inputs with a registered output.
- Sweep mode: walks every input combination itself, in binary or Gray order, under a valid/ready handshake, so truth-table benches stop hand-rolling the input loop.

Parameters:
- N_IN, 4, number of inputs; table depth is 2^N_IN.
- N_OUT, 10, number of outputs (tables).
- SEL_W, $clog2(N_OUT) (min 1), width of the table select.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- in  in  N_IN  live inputs for direct mode; bit N_IN-1 is the high bit (w), bit 0 the low bit (z).
- cfg_we  in  1  table write strobe.
- cfg_sel  in  SEL_W  index of the table to write.
- cfg_data  in  2^N_IN  new truth table; bit k is the output for input value k.
- start  in  1  one-cycle pulse that begins a sweep.
- gray  in  1  sweep order: 0 = binary, 1 = Gray code; sampled on the accepted start.
- out_rdy  in  1  consumer ready.
- f  out  N_OUT  registered outputs; bit j comes from table j.
- out_idx  out  N_IN  input value that produced f.
- out_vld  out  1  f and out_idx hold a sweep result.
- busy  out  1  high in SWEEP.
- done  out  1  one-cycle pulse after the last sweep beat is accepted.
- cfg_err  out  1  one-cycle pulse when a write is rejected.

Behaviour:
- Reset (rst_n=0 at an edge):
  - f=0, out_idx=0, out_vld=0, busy=0, done=0, cfg_err=0; state IDLE; sweep counter 0.
  - Tables cleared to 0, except when N_IN=4 and N_OUT>=2:
    - table0=16'hFAC8, i.e. (w|y)&(z|x);
    - table1=16'hF8A8, i.e. w'zx+zy+wx.
  - Reset mid-sweep aborts immediately: no done pulse, and tables return to their defaults.
- States: IDLE, SWEEP, DONE.
- IDLE:
  - Each cycle f <= {table[j][in]}, out_idx <= in, out_vld=0. Latency 1 clock from in to f.
- Table writes:
  - In IDLE with cfg_we=1 and cfg_sel<N_OUT, table[cfg_sel] <= cfg_data. The new contents are visible on f from the next cycle's sample.
  - cfg_sel>=N_OUT: write dropped, cfg_err=1 next cycle.
- start in IDLE:
  - Latch gray, set counter c=0, go to SWEEP.
  - Next cycle: out_vld=1, busy=1, out_idx=map(0)=0, f=table[.][0].
- SWEEP:
  - map(c) = c in binary order, c^(c>>1) in Gray order.
  - out_idx=map(c) and f=table[.][map(c)], both held stable while out_rdy=0.
  - When out_vld&out_rdy and c<2^N_IN-1: c++, and the next beat appears on the following cycle. This gives one beat per cycle under continuous ready.
  - When out_vld&out_rdy and c=2^N_IN-1: go to DONE; out_vld=0, busy=0 on the next cycle.
- DONE: done=1 for exactly one cycle, then IDLE (counter 0). Direct evaluation resumes the cycle after.
- start while busy or in DONE: ignored, and the sweep is not restarted.
- cfg_we in SWEEP or DONE: write dropped, cfg_err=1 next cycle, so the tables stay consistent within a sweep.
- cfg_we and start in the same IDLE cycle: the write is applied first and the sweep uses the new table.
- Counter is N_IN+1 bits wide internally, so there is no wrap ambiguity at 2^N_IN-1. out_idx never exceeds 2^N_IN-1.
- Changes to in during SWEEP have no effect.

Test Plan:
- Reset defaults: hold rst_n=0 for 2 clocks, release; drive in=4'b0011 -> next cycle f[0]=1, f[1]=1. Drive in=4'b1000 -> f[0]=0, f[1]=0. f[9:2]=0 throughout.
- Binary sweep, out_rdy=1: pulse start with gray=0 -> 16 consecutive beats with out_idx 0..15. f[0] sequence equals bits of 16'hFAC8 LSB-first. done pulses one cycle after beat 15; busy is high for exactly 16 cycles.
- Gray sweep with backpressure: gray=1, out_rdy toggling 1,0,1,0 -> out_idx sequence 0,1,3,2,6,7,5,4,12,13,15,14,10,11,9,8. Each beat is held unchanged across its ready-low cycles; 16 handshakes total, then done.
- Reprogramming: write cfg_sel=2, cfg_data=16'h8000 in IDLE, then in=4'hF -> f[2]=1. With in=4'hE -> f[2]=0. Write cfg_sel=10 -> cfg_err=1 and no table changes.
- Collisions: start again mid-sweep at beat 5 -> ignored, sweep continues to 15. cfg_we mid-sweep -> cfg_err=1 and later beats keep the old table. Same-cycle cfg_we+start in IDLE -> the sweep reflects the new table.
- Reset mid-operation: assert rst_n=0 at beat 7 of a sweep -> next cycle out_vld=0, busy=0, no done, tables back to defaults. A fresh start then sweeps from out_idx=0.

Source files
------------

// File: rtl/breadboard_lut_sweep.sv
// Programmable truth-table breadboard: one LUT per output, evaluated either
// directly from live inputs or by an internal binary/Gray sweep under valid/ready.
module breadboard_lut_sweep #(
   parameter int N_IN  = 4,
   parameter int N_OUT = 10,
   parameter int SEL_W = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N_IN-1:0]      in,
   input  logic                 cfg_we,
   input  logic [SEL_W-1:0]     cfg_sel,
   input  logic [(1<<N_IN)-1:0] cfg_data,
   input  logic                 start,
   input  logic                 gray,
   input  logic                 out_rdy,
   output logic [N_OUT-1:0]     f,
   output logic [N_IN-1:0]      out_idx,
   output logic                 out_vld,
   output logic                 busy,
   output logic                 done,
   output logic                 cfg_err
);
   localparam int DEPTH = 1 << N_IN;
   localparam logic [N_IN:0] LAST = (N_IN+1)'(DEPTH - 1);

   typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

   state_t           state, state_nxt;
   logic [DEPTH-1:0] tbl    [N_OUT];
   logic [DEPTH-1:0] tbl_wr [N_OUT];
   logic [N_IN:0]    cnt, cnt_nxt;
   logic             gray_q;
   logic             wr_ok, bad_wr, beat_acc, last_beat, go, upd;
   logic [N_IN-1:0]  idx_nxt, lk_idx;
   logic [N_OUT-1:0] f_nxt;

   function automatic logic [DEPTH-1:0] tbl_default(input int j);
      logic [DEPTH-1:0] v;
      v = '0;
      if (N_IN == 4 && N_OUT >= 2) begin
         if (j == 0)
            v = DEPTH'(16'hFAC8);
         else if (j == 1)
            v = DEPTH'(16'hF8A8);
      end
      return v;
   endfunction

   function automatic logic [N_IN-1:0] seq_map(input logic [N_IN:0] c, input logic g);
      logic [N_IN-1:0] b;
      b = c[N_IN-1:0];
      return g ? (b ^ (b >> 1)) : b;
   endfunction

   always_comb begin
      wr_ok     = cfg_we && (int'(cfg_sel) < N_OUT) && (state == IDLE);
      bad_wr    = cfg_we && !wr_ok;
      go        = (state == IDLE) && start;
      beat_acc  = (state == SWEEP) && out_rdy;
      last_beat = (cnt == LAST);
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = SWEEP;
               cnt_nxt   = '0;
            end
         end
         SWEEP: begin
            if (beat_acc) begin
               if (last_beat)
                  state_nxt = DONE;
               else
                  cnt_nxt = cnt + 1'b1;
            end
         end
         DONE: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
         default: state_nxt = IDLE;
      endcase
      idx_nxt = seq_map(cnt_nxt, go ? gray : gray_q);
      upd     = (state == IDLE) || (beat_acc && !last_beat);
   end

   // A write issued together with start must already be seen by the first beat,
   // so the start path looks up the post-write tables; direct mode sees it a cycle later.
   always_comb begin
      lk_idx = go ? idx_nxt : ((state == IDLE) ? in : idx_nxt);
      f_nxt  = '0;
      for (int j = 0; j < N_OUT; j++) begin
         tbl_wr[j] = (wr_ok && cfg_sel == SEL_W'(j)) ? cfg_data : tbl[j];
         f_nxt[j]  = go ? tbl_wr[j][lk_idx] : tbl[j][lk_idx];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt     <= '0;
         gray_q  <= 1'b0;
         f       <= '0;
         out_idx <= '0;
         cfg_err <= 1'b0;
         for (int j = 0; j < N_OUT; j++)
            tbl[j] <= tbl_default(j);
      end else begin
         cnt     <= cnt_nxt;
         cfg_err <= bad_wr;
         for (int j = 0; j < N_OUT; j++)
            tbl[j] <= tbl_wr[j];
         if (go)
            gray_q <= gray;
         if (upd) begin
            f       <= f_nxt;
            out_idx <= lk_idx;
         end
      end
   end

   assign out_vld = (state == SWEEP);
   assign busy    = (state == SWEEP);
   assign done    = (state == DONE);

endmodule
